// File: rtl/tile_line_fetcher_if.sv
// ----------------------------------------------------------------------------
// tile_line_fetcher_if
//
// Read-only memory bus between the tile line fetcher and its two backing
// memories: the tile name buffer (tb_*) and the tile pattern memory (tg_*).
//
// Handshake: there is no valid/ready pair. Both memories are fixed-latency
// synchronous reads. The address presented in cycle N is sampled on the
// following rising edge, and its data is valid throughout cycle N+1.
// Neither memory can stall. The write enables are always driven low.
//
// Signals
//   tb_addr    [8:0]   tile buffer address          (master -> slave)
//   tb_rw              tile buffer write enable     (master -> slave)
//   tb_rd_data [31:0]  tile buffer read data        (slave -> master)
//   tg_addr    [10:0]  tile graphics address        (master -> slave)
//   tg_rw              tile graphics write enable   (master -> slave)
//   tg_rd_data [31:0]  tile graphics read data      (slave -> master)
// ----------------------------------------------------------------------------
interface tile_line_fetcher_if;
    logic [8:0]  tb_addr;
    logic        tb_rw;
    logic [31:0] tb_rd_data;
    logic [10:0] tg_addr;
    logic        tg_rw;
    logic [31:0] tg_rd_data;

    modport master (
        output tb_addr, tb_rw, tg_addr, tg_rw,
        input  tb_rd_data, tg_rd_data
    );

    modport slave (
        input  tb_addr, tb_rw, tg_addr, tg_rw,
        output tb_rd_data, tg_rd_data
    );
endinterface

// File: rtl/tile_line_fetcher.sv
// ----------------------------------------------------------------------------
// tile_line_fetcher
//
// Purpose
//   This is the background pre-fetch stage that sits in front of palette
//   lookup. Each accepted line_start does the following:
//     - It swaps the ping-pong line buffer banks.
//     - It walks the TILES_X tile-buffer entries of the requested scanline.
//     - It reads four pattern words per tile and unpacks them, as 4-bit pixel
//       indices, into the bank that is not being displayed.
//   The display side registers the nibble at pix_x from the display bank.
//
// Optional feature (macro TILE_FLIP_EN)
//   When this macro is defined, tile entry bit 4 selects a horizontal flip and
//   bit 5 selects a vertical flip. When it is undefined, these bits are ignored
//   and the timing is identical.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   line_start   one-cycle pulse: fetch line_num and swap banks
//   line_num     scanline to fetch (line_num >= LINES is ignored)
//   mem          tile buffer / tile graphics read bus (master side)
//   pix_x        display pixel column
//   pix_index    registered pixel index for pix_x (1 cycle latency)
//   pal_addr     pix_index[2:0]
//   busy         fetch in progress (exactly 6*TILES_X cycles)
//   done         one-cycle pulse on the last fetch cycle
//   overrun      sticky: a line_start arrived while busy
//   dbg_state    current FSM state
// ----------------------------------------------------------------------------
module tile_line_fetcher #(
    parameter int TILES_X = 20,
    parameter int LINES   = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_start,
    input  logic [8:0]          line_num,
    tile_line_fetcher_if.master mem,
    input  logic [9:0]          pix_x,
    output logic [3:0]          pix_index,
    output logic [2:0]          pal_addr,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [2:0]          dbg_state
);

    localparam int         WORDS    = TILES_X * 4;
    localparam logic [9:0] LINE_PX  = 10'(TILES_X * 32);
    localparam logic [8:0] LINES_W  = 9'(LINES);
    localparam logic [8:0] TILES_W  = 9'(TILES_X);
    localparam logic [4:0] LAST_COL = 5'(TILES_X - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TB_RD  = 3'd1,
        S_TB_LAT = 3'd2,
        S_TG0    = 3'd3,
        S_TG1    = 3'd4,
        S_TG2    = 3'd5,
        S_TG3    = 3'd6
    } state_t;

    state_t      state_q;
    logic [4:0]  col_q;
    logic [8:0]  base_q;
    logic [8:0]  tb_addr_q;
    logic [4:0]  row_q;
    logic [3:0]  tile_q;
    logic        hflip_q;
    logic        vflip_q;
    logic        busy_q;
    logic        done_q;
    logic        overrun_q;
    logic        disp_bank_q;
    logic [1:0]  valid_q;        // bank holds a completely fetched line
    logic [3:0]  pix_index_q;
    logic [3:0]  pix_index_d;

    logic [31:0] line_mem [2][WORDS];

    logic        accept;
    logic [8:0]  line_base;
    logic        fill_bank;
    logic        hflip_new;
    logic        vflip_new;
    logic        unused_rd;
    logic [3:0]  tile_sel;
    logic        vflip_sel;
    logic [4:0]  row_sel;
    logic [1:0]  w_rd;
    logic [1:0]  w_wr;
    logic        wr_en;
    logic [6:0]  wr_idx;
    logic [31:0] wr_data;
    logic [31:0] rd_word;

    assign accept    = line_start && (state_q == S_IDLE) && (line_num < LINES_W);
    assign line_base = {5'd0, line_num[8:5]} * TILES_W;
    assign fill_bank = ~disp_bank_q;

`ifdef TILE_FLIP_EN
    function automatic logic [31:0] reverse_nibbles(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = d[4*(7-i) +: 4];
        end
        return r;
    endfunction

    assign hflip_new = mem.tb_rd_data[4];
    assign vflip_new = mem.tb_rd_data[5];
    assign unused_rd = ^mem.tb_rd_data[31:6];
    // A mirrored tile stores pixel p at position 31-p. This reverses both the
    // word order within the tile and the nibble order within each word.
    assign wr_data   = hflip_q ? reverse_nibbles(mem.tg_rd_data) : mem.tg_rd_data;
`else
    assign hflip_new = 1'b0;
    assign vflip_new = 1'b0;
    assign unused_rd = ^mem.tb_rd_data[31:4];
    assign wr_data   = mem.tg_rd_data;
`endif

    // The tile id is only available during TB_LAT, straight from the tile
    // buffer. The pattern address for word 0 therefore uses the live read
    // data, and later words use the latched copy.
    always_comb begin
        tile_sel  = tile_q;
        vflip_sel = vflip_q;
        w_rd      = 2'd0;
        w_wr      = 2'd0;
        wr_en     = 1'b0;
        case (state_q)
            S_TB_LAT: begin
                tile_sel  = mem.tb_rd_data[3:0];
                vflip_sel = vflip_new;
            end
            S_TG0: begin w_rd = 2'd1; w_wr = 2'd0; wr_en = 1'b1; end
            S_TG1: begin w_rd = 2'd2; w_wr = 2'd1; wr_en = 1'b1; end
            S_TG2: begin w_rd = 2'd3; w_wr = 2'd2; wr_en = 1'b1; end
            S_TG3: begin w_rd = 2'd3; w_wr = 2'd3; wr_en = 1'b1; end
            default: begin end
        endcase
        row_sel = vflip_sel ? ~row_q : row_q;
        wr_idx  = {col_q, (hflip_q ? ~w_wr : w_wr)};
    end

    assign mem.tb_addr = tb_addr_q;
    assign mem.tb_rw   = 1'b0;
    assign mem.tg_addr = {tile_sel, row_sel, w_rd};
    assign mem.tg_rw   = 1'b0;

    // Fetch FSM. The outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            col_q       <= 5'd0;
            base_q      <= 9'd0;
            tb_addr_q   <= 9'd0;
            row_q       <= 5'd0;
            tile_q      <= 4'd0;
            hflip_q     <= 1'b0;
            vflip_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            disp_bank_q <= 1'b0;
            valid_q     <= 2'b00;
        end else begin
            done_q <= 1'b0;
            if (line_start && busy_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // The retiring display bank becomes the fill bank and
                        // is not shown again until it is fully rewritten.
                        disp_bank_q          <= ~disp_bank_q;
                        valid_q[disp_bank_q] <= 1'b0;
                        row_q                <= line_num[4:0];
                        base_q               <= line_base;
                        tb_addr_q            <= line_base;
                        col_q                <= 5'd0;
                        busy_q               <= 1'b1;
                        state_q              <= S_TB_RD;
                    end
                end
                S_TB_RD: state_q <= S_TB_LAT;
                S_TB_LAT: begin
                    tile_q  <= mem.tb_rd_data[3:0];
                    hflip_q <= hflip_new;
                    vflip_q <= vflip_new;
                    state_q <= S_TG0;
                end
                S_TG0: state_q <= S_TG1;
                S_TG1: state_q <= S_TG2;
                S_TG2: begin
                    state_q <= S_TG3;
                    if (col_q == LAST_COL) begin
                        done_q <= 1'b1;
                    end
                end
                S_TG3: begin
                    if (col_q == LAST_COL) begin
                        valid_q[fill_bank] <= 1'b1;
                        busy_q             <= 1'b0;
                        state_q            <= S_IDLE;
                    end else begin
                        col_q     <= col_q + 5'd1;
                        tb_addr_q <= base_q + {4'd0, col_q} + 9'd1;
                        state_q   <= S_TB_RD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line buffer storage. It has no reset. Stale contents are masked by
    // valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[fill_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_word = line_mem[disp_bank_q][pix_x[9:3]];

    always_comb begin
        pix_index_d = 4'd0;
        if ((pix_x < LINE_PX) && valid_q[disp_bank_q]) begin
            pix_index_d = rd_word[{pix_x[2:0], 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_index_q <= 4'd0;
        end else begin
            pix_index_q <= pix_index_d;
        end
    end

    assign pix_index = pix_index_q;
    assign pal_addr  = pix_index_q[2:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// ----------------------------------------------------------------------------
// tb_tile_line_fetcher
//
// Bench for tile_line_fetcher. The tile buffer and pattern memories are
// modelled as arrays with 1-cycle read latency. Each accepted line is
// snapshotted into an expected 640-pixel array, computed straight from the
// addressing rules. A posedge process checks busy, done, overrun, addresses
// and pixels every cycle. The main initial block drives the scenarios and
// adds literal expectations.
// Set the TILE_FLIP_EN macro to match the RTL build.
// ----------------------------------------------------------------------------
module tb_tile_line_fetcher;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_num = 9'd0;
  logic [9:0] pix_x = 10'd0;
  logic [3:0] pix_index;
  logic [2:0] pal_addr;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [2:0] dbg_state;

  tile_line_fetcher_if mem_if ();

  tile_line_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_num   (line_num),
    .mem        (mem_if),
    .pix_x      (pix_x),
    .pix_index  (pix_index),
    .pal_addr   (pal_addr),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- memories ----------------
  logic [31:0] tb_mem [512];
  logic [31:0] tg_mem [2048];

  always @(posedge clk) begin
    mem_if.tb_rd_data <= tb_mem[mem_if.tb_addr];
    mem_if.tg_rd_data <= tg_mem[mem_if.tg_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected pixel x of scanline ln, derived from the addressing rules.
  function automatic logic [3:0] model_pixel(input int ln, input int x);
    int          col;
    int          src;
    int          row;
    logic [31:0] ent;
    logic [31:0] pat;
    col = x / 32;
    src = x % 32;
    row = ln % 32;
    ent = tb_mem[(ln / 32) * 20 + col];
`ifdef TILE_FLIP_EN
    if (ent[4]) src = 31 - src;
    if (ent[5]) row = 31 - row;
`endif
    pat = tg_mem[int'(ent[3:0]) * 128 + row * 4 + src / 8];
    return pat[(src % 8) * 4 +: 4];
  endfunction

  function automatic logic [31:0] model_tg(input int ln, input int col, input int w);
    int          row;
    logic [31:0] ent;
    row = ln % 32;
    ent = tb_mem[(ln / 32) * 20 + col];
`ifdef TILE_FLIP_EN
    if (ent[5]) row = 31 - row;
`endif
    return 32'(int'(ent[3:0]) * 128 + row * 4 + w);
  endfunction

  // Model state
  int         left = 0;        // busy cycles still to come
  bit         over_m = 1'b0;
  int         fill_line = 0;
  bit         fill_done = 1'b0;
  bit         disp_valid = 1'b0;
  logic [3:0] fill_pix [640];
  logic [3:0] disp_pix [640];

  always begin
    logic [3:0] e_pix;
    bit         e_pix_chk;
    int         c;
    @(posedge clk);
    if (!reset) begin
      left = 0; over_m = 1'b0; fill_done = 1'b0; disp_valid = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_pix_index", pix_index, 0);
      check("rst_pal_addr", pal_addr, 0);
      check("rst_tb_addr", mem_if.tb_addr, 0);
      check("rst_tg_addr", mem_if.tg_addr, 0);
    end else begin
      e_pix_chk = (pix_x >= 640) || disp_valid;
      e_pix     = (pix_x >= 640) ? 4'd0 : disp_pix[pix_x];
      if (left > 0) begin
        if (line_start) over_m = 1'b1;
        left--;
        if (left == 0) fill_done = 1'b1;
      end else if (line_start && line_num < 480) begin
        disp_valid = fill_done;
        if (fill_done) disp_pix = fill_pix;
        fill_line = int'(line_num);
        fill_done = 1'b0;
        for (int x = 0; x < 640; x++) fill_pix[x] = model_pixel(fill_line, x);
        left = 120;
      end
      #1;
      check("busy", busy, (left > 0) ? 1 : 0);
      check("done", done, (left == 1) ? 1 : 0);
      check("overrun", overrun, over_m);
      check("tb_rw", mem_if.tb_rw, 0);
      check("tg_rw", mem_if.tg_rw, 0);
      if (e_pix_chk) begin
        check("pix_index", pix_index, e_pix);
        check("pal_addr", pal_addr, e_pix[2:0]);
      end
      if (left > 0) begin
        c = 120 - left;
        if (c % 6 == 0) check("tb_addr", mem_if.tb_addr, 32'((fill_line / 32) * 20 + c / 6));
        if (c % 6 >= 1 && c % 6 <= 4)
          check("tg_addr", mem_if.tg_addr, model_tg(fill_line, c / 6, c % 6 - 1));
      end
    end
  end

  // ---------------- drivers ----------------
  bit manual_pix = 1'b0;

  always @(negedge clk) begin
    if (!manual_pix) pix_x = 10'($urandom_range(0, 699));
  end

  task automatic start_line(input int ln);
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 9'(ln);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  // Starts a line and follows it to completion. It counts busy and done
  // cycles, checks the first tile's addresses, and optionally injects a
  // line_start in the middle of the fetch.
  task automatic fetch_line(input int ln, input int exp_tb0, input int exp_row,
                            input int exp_tg0, input int inject_ln);
    int nb;
    int nd;
    int guard;
    nb = 0; nd = 0; guard = 0;
    start_line(ln);
    while (busy && guard < 300) begin
      nb++;
      nd += int'(done);
      if (nb == 1) check("first_tb_addr", mem_if.tb_addr, exp_tb0);
      if (nb == 2) check("first_tg_row", mem_if.tg_addr[6:2], exp_row);
      if (nb >= 2 && nb <= 5 && exp_tg0 >= 0)
        check("first_tg_addr", mem_if.tg_addr, exp_tg0 + nb - 2);
      if (nb == 30 && inject_ln >= 0) begin
        line_start = 1'b1;
        line_num   = 9'(inject_ln);
      end else begin
        line_start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    line_start = 1'b0;
    check("busy_cycles", nb, 120);
    check("done_pulses", nd, 1);
  endtask

  initial begin
    logic seen_busy;
    for (int i = 0; i < 512; i++) tb_mem[i] = $urandom;
    for (int i = 0; i < 2048; i++) tg_mem[i] = $urandom;
`ifdef TILE_FLIP_EN
    tb_mem[0] = 32'h13;
`else
    tb_mem[0] = 32'h3;
`endif
    tg_mem[384] = 32'h7654_3210;

    // Reset, then hold idle.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("post_rst_pix", pix_index, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_tb_rw", mem_if.tb_rw, 0);
    check("post_rst_tg_rw", mem_if.tg_rw, 0);
    seen_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check("idle_200_busy", seen_busy, 0);

    // Line 0: tile 3, pattern word 384.
    fetch_line(0, 0, 0, 384, -1);

    // Swap to line 0's bank and read its first tile.
    start_line(5);
    manual_pix = 1'b1;
    for (int k = 0; k < 8; k++) begin
`ifdef TILE_FLIP_EN
      pix_x = 10'(31 - k);
`else
      pix_x = 10'(k);
`endif
      @(negedge clk);
      check("lit_pix_index", pix_index, k);
      check("lit_pal_addr", pal_addr, k);
    end
    manual_pix = 1'b0;
    wait_idle();

    // Line 37: entries 20..39, row 5. Inject a line_start midway.
    tb_mem[20] = tb_mem[20] & ~32'h30;
    fetch_line(37, 20, 5, -1, 100);
    check("overrun_set", overrun, 1);

    // An out-of-range line is ignored.
    start_line(480);
    repeat (5) begin
      @(negedge clk);
      check("l480_busy", busy, 0);
    end
    manual_pix = 1'b1;
    pix_x = 10'd700;
    @(negedge clk);
    check("pix_700", pix_index, 0);
    manual_pix = 1'b0;

    // Random lines, memory updates and overlapping starts.
    for (int it = 0; it < 14; it++) begin
      repeat (8) begin
        tb_mem[$urandom_range(0, 299)] = $urandom;
        tg_mem[$urandom_range(0, 2047)] = $urandom;
      end
      start_line($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 100)) @(negedge clk);
        line_start = 1'b1;
        line_num   = 9'($urandom_range(0, 511));
        @(negedge clk);
        line_start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a fetch.
    start_line(10);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_line($urandom_range(0, 479));
      wait_idle();
      repeat (30) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_line_fetcher.md
Name: tile_line_fetcher

Overview:
- Background pre-fetch stage sitting between the tile name buffer / tile pattern memories and the palette lookup.
- On each line_start it walks the 20 tile-buffer entries for the requested scanline and reads 4 pattern words per tile.
- It unpacks 640 4-bit pixel indices into one bank of an internal ping-pong line buffer.
- While that bank fills, the display side reads the other bank by pixel x and drives the palette address.

Parameters:
- TILES_X, 20, tiles per row (32 px each, 640 px line)
- LINES, 480, visible lines; line_num >= LINES is ignored

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- line_start  in  1  one-cycle pulse: begin fetch for line_num and swap banks
- line_num  in  9  scanline to fetch (0..479)
- tb_addr  out  9  tile buffer address
- tb_rw  out  1  tile buffer write enable, constant 0
- tb_rd_data  in  32  tile buffer read data, valid 1 cycle after tb_addr
- tg_addr  out  11  tile graphics address
- tg_rw  out  1  tile graphics write enable, constant 0
- tg_rd_data  in  32  tile graphics read data, valid 1 cycle after tg_addr
- pix_x  in  10  display pixel column
- pix_index  out  4  registered pixel index for pix_x
- pal_addr  out  3  palette address = pix_index[2:0], same cycle as pix_index
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse on the last fetch cycle of a line
- overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- Reset values: tb_addr=0, tg_addr=0, pix_index=0, pal_addr=0, busy=0, done=0, overrun=0, display bank=0, FSM=IDLE. Line buffer contents are undefined after reset.
- Accepting a line_start:
  - Accepted only when busy=0 and line_num<LINES.
  - Display bank toggles on the accepted cycle; the fetch writes the other bank.
  - busy rises on the next cycle.
- line_start with line_num>=LINES: no swap, no fetch, no flag.
- line_start while busy=1: ignored, no swap, overrun<=1 until reset.
- Addressing:
  - tb_addr = (line_num[8:5])*20 + col, col 0..19.
  - Tile id = tb_rd_data[3:0].
  - tg_addr = {tile_id, line_num[4:0], w[1:0]}.
  - Pattern word w holds pixels 8w..8w+7; pixel k of the word is in bits [4k+3:4k].
- FSM: IDLE -> TB_RD -> TB_LAT -> TG0 -> TG1 -> TG2 -> TG3 -> (TB_RD of next col, or IDLE after col 19). 6 cycles per tile.
  - TB_RD: drive tb_addr.
  - TB_LAT: latch tile id, drive tg_addr w=0.
  - TG0..TG2: drive w=1..3 and write the data of the previous word.
  - TG3: write word 3 data.
- Timing:
  - busy is high for exactly 120 cycles.
  - done pulses on the 120th busy cycle (the TG3 of col 19).
  - busy falls the cycle after done.
- Display side: pix_index and pal_addr are registered from the display bank at pix_x, giving 1-cycle latency. pix_x>=640 gives pix_index=0.
- Reset mid-fetch: the FSM returns to IDLE immediately and the partially filled bank is not displayed as valid.

Optional Feature:
- Macro: TILE_FLIP_EN.
- When defined, tb_rd_data[4] selects horizontal flip and tb_rd_data[5] selects vertical flip.
  - hflip: pixel p of the tile is stored at position 31-p.
  - vflip: row = ~line_num[4:0].
- When undefined, bits [5:4] are ignored and timing is identical.

Test Plan:
- Reset, then hold: all outputs 0, tb_rw=tg_rw=0, busy stays 0 for 200 cycles.
- line_start with line_num=0, tile buffer entry 0=3, pattern word addr 384=0x76543210 -> tb_addr sequence 0..19, tg_addr 384..387 for col 0, busy exactly 120 cycles, done one pulse. After the next line_start (swap), pix_x=0..7 gives pix_index 0..7 one cycle later and pal_addr matching.
- line_num=37 -> tb_addr 20..39, tg_addr row field 5.
- line_start while busy -> overrun=1 (sticky through later lines), fetch continues unaffected, no bank swap.
- line_num=480 -> busy stays 0, no bank swap, display contents unchanged. pix_x=700 -> pix_index=0.
- With TILE_FLIP_EN: entry 0x13, pattern 0x76543210 at row 0 -> pix_x=31..24 read 0..7. Row selection uses ~line_num[4:0].
